// File: rtl/fdiv_arbiter.sv
// rtl/fdiv_arbiter.sv - round-robin front end sharing one Goldschmidt fraction divider between two requesters
// One operation in flight; a divider that never completes is answered with q=0, err=1 after TIMEOUT WAIT cycles.
module fdiv_arbiter #(
  parameter int TIMEOUT = 15
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        req0_valid,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        req1_ready,
  output logic        rsp0_valid,
  output logic [31:0] rsp0_q,
  output logic        rsp0_err,
  input  logic        rsp0_ready,
  output logic        rsp1_valid,
  output logic [31:0] rsp1_q,
  output logic        rsp1_err,
  input  logic        rsp1_ready,
  output logic        div_start,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  input  logic        div_busy,
  input  logic        div_ready,
  input  logic [31:0] div_q
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t        state;
  logic          owner;
  logic          rr;
  logic [CW-1:0] cnt;
  logic [31:0]   a_r;
  logic [31:0]   b_r;
  logic [31:0]   q_r;
  logic          err_r;
  logic          grant0;
  logic          grant1;
  logic          handshake;

  // Outputs are gated by resetn so they read 0 during the reset cycle, whatever state was left behind.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (resetn && state == IDLE) begin
      grant0 = req0_valid && (!req1_valid || !rr);
      grant1 = req1_valid && (!req0_valid || rr);
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  assign div_start = resetn && (state == ISSUE) && !div_busy;
  assign div_a     = div_start ? a_r : 32'd0;
  assign div_b     = div_start ? b_r : 32'd0;

  assign rsp0_valid = resetn && (state == RESP) && !owner;
  assign rsp1_valid = resetn && (state == RESP) && owner;
  assign rsp0_q     = rsp0_valid ? q_r : 32'd0;
  assign rsp1_q     = rsp1_valid ? q_r : 32'd0;
  assign rsp0_err   = rsp0_valid & err_r;
  assign rsp1_err   = rsp1_valid & err_r;

  assign handshake = owner ? rsp1_ready : rsp0_ready;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state <= IDLE;
      owner <= 1'b0;
      rr    <= 1'b0;
      cnt   <= '0;
      a_r   <= 32'd0;
      b_r   <= 32'd0;
      q_r   <= 32'd0;
      err_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant0 || grant1) begin
            owner <= grant1;
            a_r   <= grant1 ? req1_a : req0_a;
            b_r   <= grant1 ? req1_b : req0_b;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          if (!div_busy) begin
            cnt   <= '0;
            state <= WAIT;
          end
        end
        WAIT: begin
          // cnt counts completed WAIT cycles; the TIMEOUT-th empty one gives up.
          if (div_ready) begin
            q_r   <= div_q;
            err_r <= 1'b0;
            state <= RESP;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            q_r   <= 32'd0;
            err_r <= 1'b1;
            state <= RESP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RESP: begin
          if (handshake) begin
            rr    <= ~owner;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fdiv_arbiter.sv
// tb/tb_fdiv_arbiter.sv - randomized self-checking bench for fdiv_arbiter
// A behavioural 5-iteration divider and a round-robin order model supply every expected value.
module tb_fdiv_arbiter;

  localparam int TO = 15;

  logic        clock = 1'b0;
  logic        resetn;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        rsp0_valid, rsp1_valid, rsp0_err, rsp1_err, rsp0_ready, rsp1_ready;
  logic [31:0] rsp0_q, rsp1_q;
  logic        div_start, div_busy, div_ready;
  logic [31:0] div_a, div_b, div_q;

  int total = 0;
  int bad = 0;
  int m_rr = 0;

  logic        m_busy, m_ready;
  logic [31:0] m_q;
  int          m_left;
  logic        never_ready = 1'b0;
  logic        force_busy = 1'b0;
  logic        stray = 1'b0;
  logic [31:0] stray_q = 32'd0;

  assign div_busy  = m_busy | force_busy;
  assign div_ready = m_ready | stray;
  assign div_q     = stray ? stray_q : m_q;

  fdiv_arbiter #(.TIMEOUT(TO)) dut (
    .clock(clock), .resetn(resetn),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
    .rsp0_valid(rsp0_valid), .rsp0_q(rsp0_q), .rsp0_err(rsp0_err), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_q(rsp1_q), .rsp1_err(rsp1_err), .rsp1_ready(rsp1_ready),
    .div_start(div_start), .div_a(div_a), .div_b(div_b),
    .div_busy(div_busy), .div_ready(div_ready), .div_q(div_q)
  );

  always #5 clock = ~clock;

  // Divider: quotient = a / b with 31 fraction bits, ready pulse 5 cycles after start.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      m_busy <= 1'b0; m_ready <= 1'b0; m_q <= 32'd0; m_left <= 0;
    end else begin
      m_ready <= 1'b0;
      if (div_start && !never_ready) begin
        m_busy <= 1'b1;
        m_left <= 4;
        m_q    <= 32'((64'(div_a) << 31) / 64'(div_b));
      end else if (m_left != 0) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_ready <= 1'b1;
          m_busy  <= 1'b0;
        end
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;
    resetn = 0;
    step();
    step();
    resetn = 1;
    m_rr = 0;
  endtask

  // One full operation: grant, issue, wait, response held for 'hold' cycles, handshake.
  task automatic serve(input logic v0, input logic v1, input logic [31:0] a0, input logic [31:0] b0,
                       input logic [31:0] a1, input logic [31:0] b1,
                       input int hold, input int busy_cyc, input bit to_mode);
    int w, c;
    logic [31:0] ea, eb, eq;
    logic ee, leak;
    req0_valid = v0; req1_valid = v1;
    req0_a = a0; req0_b = b0; req1_a = a1; req1_b = b1;
    w  = (v0 && v1) ? m_rr : (v0 ? 0 : 1);
    ea = (w == 1) ? a1 : a0;
    eb = (w == 1) ? b1 : b0;
    eq = to_mode ? 32'd0 : 32'((64'(ea) << 31) / 64'(eb));
    ee = to_mode;
    never_ready = to_mode;
    force_busy  = (busy_cyc > 0);
    #1;
    total++;
    if ({req1_ready, req0_ready} !== ((w == 1) ? 2'b10 : 2'b01)) begin
      bad++; $display("FAIL grant: ready1/0=%b%b want winner %0d", req1_ready, req0_ready, w);
    end
    step();
    if (w == 1) begin req1_valid = 0; req1_a = $urandom; req1_b = $urandom; end
    else        begin req0_valid = 0; req0_a = $urandom; req0_b = $urandom; end
    for (int i = 0; i < busy_cyc; i++) begin
      #1;
      total++;
      if (div_start !== 1'b0 || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
        bad++; $display("FAIL issue_hold: div_start=%b ready=%b%b want 0", div_start, req1_ready, req0_ready);
      end
      step();
    end
    force_busy = 0;
    #1;
    total++;
    if (div_start !== 1'b1 || div_a !== ea || div_b !== eb || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      bad++; $display("FAIL issue: start=%b a=%h b=%h want 1 %h %h", div_start, div_a, div_b, ea, eb);
    end
    c = 0;
    leak = 0;
    while (!(rsp0_valid || rsp1_valid) && c < TO + 10) begin
      step();
      c++;
      #1;
      if (req0_ready || req1_ready || (c > 1 && div_start)) leak = 1;
    end
    total++;
    if (c !== (to_mode ? TO + 1 : 6) || leak) begin
      bad++; $display("FAIL latency: rsp after %0d cycles leak=%b want %0d", c, leak, to_mode ? TO + 1 : 6);
    end
    total++;
    if ({rsp1_valid, rsp0_valid} !== ((w == 1) ? 2'b10 : 2'b01) ||
        ((w == 1) ? rsp1_q : rsp0_q) !== eq || ((w == 1) ? rsp1_err : rsp0_err) !== ee) begin
      bad++; $display("FAIL response: valid=%b%b q0=%h q1=%h err=%b%b want owner %0d q=%h err=%b",
                      rsp1_valid, rsp0_valid, rsp0_q, rsp1_q, rsp1_err, rsp0_err, w, eq, ee);
    end
    for (int i = 0; i < hold; i++) begin
      if (w == 1) rsp0_ready = 1'($urandom_range(0, 1));
      else        rsp1_ready = 1'($urandom_range(0, 1));
      if (to_mode && i == 0) begin stray = 1; stray_q = $urandom | 32'h1; end
      step();
      stray = 0;
      #1;
      total++;
      if ({rsp1_valid, rsp0_valid} !== ((w == 1) ? 2'b10 : 2'b01) ||
          ((w == 1) ? rsp1_q : rsp0_q) !== eq || ((w == 1) ? rsp1_err : rsp0_err) !== ee ||
          req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
        bad++; $display("FAIL hold: valid=%b%b q0=%h q1=%h ready=%b%b want owner %0d q=%h",
                        rsp1_valid, rsp0_valid, rsp0_q, rsp1_q, req1_ready, req0_ready, w, eq);
      end
    end
    if (w == 1) begin rsp1_ready = 1; rsp0_ready = 0; end
    else        begin rsp0_ready = 1; rsp1_ready = 0; end
    step();
    rsp0_ready = 0; rsp1_ready = 0;
    #1;
    total++;
    if ({rsp1_valid, rsp0_valid, rsp1_err, rsp0_err} !== 4'b0 || rsp0_q !== 32'd0 || rsp1_q !== 32'd0) begin
      bad++; $display("FAIL handshake: valid=%b%b q0=%h q1=%h want all 0", rsp1_valid, rsp0_valid, rsp0_q, rsp1_q);
    end
    m_rr = 1 - w;
  endtask

  task automatic test_reset();
    resetn = 0;
    req0_valid = 1; req1_valid = 1; rsp0_ready = 1; rsp1_ready = 1;
    req0_a = 32'h80000000; req0_b = 32'h80000000; req1_a = 32'h80000000; req1_b = 32'h80000000;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_err, rsp1_err, div_start,
           rsp0_q, rsp1_q, div_a, div_b} !== '0) begin
        bad++; $display("FAIL reset_outputs: ready=%b%b valid=%b%b start=%b want all 0",
                        req1_ready, req0_ready, rsp1_valid, rsp0_valid, div_start);
      end
    end
    req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;
    resetn = 1;
    m_rr = 0;
  endtask

  task automatic test_req0();
    serve(1, 0, 32'h80000000, 32'h80000000, 32'h0, 32'h0, 0, 0, 0);
  endtask

  task automatic test_req1();
    serve(0, 1, 32'h0, 32'h0, 32'h80000000, 32'hC0000000, 1, 0, 0);
  endtask

  task automatic test_arbitration();
    apply_reset();
    for (int i = 0; i < 4; i++)
      serve(1, 1, 32'h80000000 | $urandom, 32'h80000000 | $urandom,
            32'h80000000 | $urandom, 32'h80000000 | $urandom, 0, 0, 0);
  endtask

  task automatic test_backpressure();
    apply_reset();
    serve(1, 1, 32'hA0000000, 32'hC0000000, 32'h90000000, 32'hF0000000, 10, 0, 0);
    serve(0, 1, 32'h0, 32'h0, 32'h90000000, 32'hF0000000, 0, 0, 0);
  endtask

  task automatic test_timeout();
    serve(1, 0, 32'hB0000000, 32'hD0000000, 32'h0, 32'h0, 3, 0, 1);
    serve(0, 1, 32'h0, 32'h0, 32'hFFFFFFFF, 32'h80000001, 0, 0, 0);
  endtask

  task automatic test_busy_hold();
    serve(1, 0, 32'hC0000000, 32'hE0000000, 32'h0, 32'h0, 0, 3, 0);
  endtask

  task automatic test_mid_reset();
    logic seen;
    req0_valid = 1; req0_a = 32'h88888888; req0_b = 32'hCCCCCCCC; req1_valid = 0;
    step();
    req0_valid = 0;
    step();
    step();
    resetn = 0;
    step();
    resetn = 1;
    m_rr = 0;
    #1;
    total++;
    if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_err, rsp1_err, div_start,
         rsp0_q, rsp1_q, div_a, div_b} !== '0) begin
      bad++; $display("FAIL mid_reset_outputs: valid=%b%b start=%b want all 0", rsp1_valid, rsp0_valid, div_start);
    end
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (rsp0_valid || rsp1_valid || div_start) seen = 1;
    end
    total++;
    if (seen !== 1'b0) begin
      bad++; $display("FAIL mid_reset_silent: activity=%b want 0", seen);
    end
    serve(1, 0, 32'h88888888, 32'hCCCCCCCC, 32'h0, 32'h0, 1, 0, 0);
  endtask

  task automatic test_random();
    int p;
    for (int i = 0; i < 40; i++) begin
      p = $urandom_range(1, 3);
      serve(p[0], p[1], 32'h80000000 | $urandom, 32'h80000000 | $urandom,
            32'h80000000 | $urandom, 32'h80000000 | $urandom,
            $urandom_range(0, 3), $urandom_range(0, 2), ($urandom_range(0, 7) == 0));
    end
  endtask

  initial begin
    resetn = 0;
    req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;
    req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
    test_reset();
    test_req0();
    test_req1();
    test_arbitration();
    test_backpressure();
    test_timeout();
    test_busy_hold();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fdiv_arbiter.md
FDIV_ARBITER -- requirements
Module: fdiv_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 15, maximum WAIT-state cycles before an error response.
REQ-002 clock  input  1  system clock; all state changes on rising edge.
REQ-003 resetn  input  1  synchronous reset, active-low; sampled on rising edge of clock.
REQ-004 reqN_valid  input  1  (N=0,1) requester N has a divide pending.
REQ-005 reqN_a, reqN_b  input  32 each  dividend/divisor fractions, .1xxx...x format.
REQ-006 reqN_ready  output  1  operands of requester N accepted this cycle.
REQ-007 rspN_valid  output  1  result for requester N held on rspN_q/rspN_err.
REQ-008 rspN_q  output  32  quotient, x.xxx...x format; rspN_err  output  1  timeout flag.
REQ-009 rspN_ready  input  1  requester N consumes the response.
REQ-010 div_start  output  1  one-cycle start to the shared Goldschmidt fraction divider.
REQ-011 div_a, div_b  output  32 each  operands to the divider, valid in the div_start cycle.
REQ-012 div_busy, div_ready  input  1 each  divider busy level; one-cycle completion pulse.
REQ-013 div_q  input  32  divider quotient, sampled only in the div_ready cycle.

Function
REQ-014 FSM states: IDLE, ISSUE, WAIT, RESP; one owner register (0/1) and a round-robin pointer rr.
REQ-015 IDLE: no reqN_valid -> stay; one valid -> grant it; both valid -> grant requester rr.
REQ-016 Grant cycle: reqN_ready=1 for the granted N only (combinational, IDLE only); latch a, b, owner; next state ISSUE.
REQ-017 ISSUE: div_busy=1 -> hold, div_start=0; div_busy=0 -> div_start=1 for exactly one cycle, div_a/div_b = latched operands; next state WAIT, timeout counter cleared.
REQ-018 WAIT: div_ready=1 -> latch div_q into result, err=0, go RESP; otherwise counter increments.
REQ-019 WAIT: counter reaching TIMEOUT without div_ready -> result=0, err=1, go RESP; later stray div_ready pulses ignored outside WAIT.
REQ-020 RESP: rsp[owner]_valid=1, q/err stable until rsp[owner]_ready=1; handshake cycle -> rr = ~owner, next IDLE.
REQ-021 rspN_ready high in the same cycle rspN_valid first rises completes in one RESP cycle.
REQ-022 rspN_ready asserted while rspN_valid=0 has no effect; the non-owner's rsp_valid stays 0.
REQ-023 No new grant while not in IDLE; reqN_ready=0 in ISSUE/WAIT/RESP regardless of reqN_valid.
REQ-024 Exactly one operation outstanding; div_start never asserted outside ISSUE or while div_busy=1.
REQ-025 Latency with the standard 5-iteration divider: grant at cycle T, div_start at T+1, div_ready at T+6, rsp_valid from T+7.
REQ-026 Requester dropping reqN_valid before grant loses nothing; operands after grant are held internally, request inputs are don't-care.
REQ-027 rspN_q and rspN_err outputs are 0 whenever rspN_valid=0.

Reset
REQ-028 resetn=0 at a clock edge: state=IDLE, rr=0, owner=0, counter=0, operand/result regs=0.
REQ-029 During and after reset: all reqN_ready, rspN_valid, rspN_q, rspN_err, div_start, div_a, div_b = 0.
REQ-030 Reset mid-operation (ISSUE/WAIT/RESP) abandons the operation silently; no response is issued; the same resetn drives the divider.

Verification
REQ-031 req0 a=0x80000000, b=0x80000000 -> reqN_ready at T, div_start at T+1, rsp0_valid at T+7, rsp0_q=0x80000000, err=0.
REQ-032 req1 a=0x80000000, b=0xC0000000 -> rsp1_q = 0x55555555 within +/-1 LSB, err=0; rsp0_valid stays 0.
REQ-033 req0 and req1 valid in the same cycle after reset -> req0 served first, then req1 (rr=1); repeat -> order alternates.
REQ-034 Divider model that never pulses div_ready -> rsp_valid with rsp_q=0, rsp_err=1 after TIMEOUT WAIT cycles.
REQ-035 rsp0_ready held low 10 cycles -> rsp0_valid/q stable, req1 not granted; assert rsp0_ready -> IDLE next cycle, req1 granted.
REQ-036 resetn=0 for one cycle during WAIT -> all outputs 0 next cycle, no response, new request then completes normally.
